tone_sequencer: RTL and testbench

- Controller that sequences the tuner's reference-tone generator.
- Drives the generator's 3-bit string select and gates and restarts it, so the tuner can play two ways:
  - Single mode: hold one chosen string.
  - Sweep mode: play all six strings (E2 A D G B E4) in order, with timed notes and silent gaps, optionally repeating.
- Sits between the user-control logic (switches/keys) and the tone generator; it never touches audio samples.

---
 rtl/tuner_pkg.sv | 27 ++
 rtl/tone_sequencer_if.sv | 25 ++
 rtl/note_timer.sv | 27 ++
 rtl/tone_sequencer.sv | 135 +++++++++++++
 tb/tb_tone_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tuner_pkg.sv
// Shared definitions for the reference-tone sequencer: FSM encoding,
// string indices and the sweep index advance.
package tuner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int         NUM_STRINGS = 6;
    localparam logic [2:0] LAST_STRING = 3'd5;

    localparam logic [2:0] STR_E2 = 3'd0;
    localparam logic [2:0] STR_A2 = 3'd1;
    localparam logic [2:0] STR_D3 = 3'd2;
    localparam logic [2:0] STR_G3 = 3'd3;
    localparam logic [2:0] STR_B3 = 3'd4;
    localparam logic [2:0] STR_E4 = 3'd5;

    // Sweep order wraps from the high E back to the low E.
    function automatic logic [2:0] next_string(input logic [2:0] idx);
        return (idx == LAST_STRING) ? STR_E2 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the user-control logic (master) and the
// tone sequencer (slave).
interface tone_sequencer_if;
    logic       start;
    logic       stop;
    logic       mode;
    logic [2:0] string_sel;
    logic       repeat_en;
    logic [2:0] select;
    logic       tone_en;
    logic       tone_restart;
    logic       busy;
    logic       done;
    logic       start_err;

    modport master (
        output start, stop, mode, string_sel, repeat_en,
        input  select, tone_en, tone_restart, busy, done, start_err
    );

    modport slave (
        input  start, stop, mode, string_sel, repeat_en,
        output select, tone_en, tone_restart, busy, done, start_err
    );
endinterface

// File: rtl/note_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the last cycle
// of a timed note or gap.
module note_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tone_sequencer.sv
// Sequences the reference-tone generator: single held string or a timed
// six-string sweep with optional gaps and repeat.
module tone_sequencer
    import tuner_pkg::*;
#(
    parameter int NOTE_CYCLES = 24000,
    parameter int GAP_CYCLES  = 4800,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              reset,
    tone_sequencer_if.slave  sif
);

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    seq_state_t       state_reg, state_next;
    logic [2:0]       index_reg, index_next;
    logic             mode_reg, mode_next;
    logic             restart_reg, restart_next;
    logic             start_err_reg, start_err_next;

    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_zero;

    note_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            index_reg     <= STR_E2;
            mode_reg      <= 1'b0;
            restart_reg   <= 1'b0;
            start_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            mode_reg      <= mode_next;
            restart_reg   <= restart_next;
            start_err_reg <= start_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        mode_next      = mode_reg;
        restart_next   = 1'b0;
        start_err_next = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (sif.start && !sif.stop) begin
                    if (sif.mode) begin
                        mode_next      = 1'b1;
                        index_next     = STR_E2;
                        state_next     = ST_PLAY;
                        restart_next   = 1'b1;
                        timer_load     = 1'b1;
                        timer_load_val = NOTE_LOAD;
                    end else if (sif.string_sel <= LAST_STRING) begin
                        mode_next      = 1'b0;
                        index_next     = sif.string_sel;
                        state_next     = ST_PLAY;
                        restart_next   = 1'b1;
                        timer_load     = 1'b1;
                        timer_load_val = NOTE_LOAD;
                    end else begin
                        start_err_next = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (sif.stop) begin
                    state_next = ST_IDLE;
                    timer_load = 1'b1;
                end else if (mode_reg && timer_zero) begin
                    if (index_reg != LAST_STRING || sif.repeat_en) begin
                        timer_load = 1'b1;
                        if (HAS_GAP) begin
                            state_next     = ST_GAP;
                            timer_load_val = GAP_LOAD;
                        end else begin
                            index_next     = next_string(index_reg);
                            restart_next   = 1'b1;
                            timer_load_val = NOTE_LOAD;
                        end
                    end else begin
                        state_next = ST_DONE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (sif.stop) begin
                    state_next = ST_IDLE;
                    timer_load = 1'b1;
                end else if (timer_zero) begin
                    // select keeps the old index through the gap; advance only now.
                    state_next     = ST_PLAY;
                    index_next     = next_string(index_reg);
                    restart_next   = 1'b1;
                    timer_load     = 1'b1;
                    timer_load_val = NOTE_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                timer_load = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign sif.select       = index_reg;
    assign sif.tone_en      = (state_reg == ST_PLAY);
    assign sif.tone_restart = restart_reg;
    assign sif.busy         = (state_reg != ST_IDLE);
    assign sif.done         = (state_reg == ST_DONE);
    assign sif.start_err    = start_err_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: one instance with gaps (NOTE=4, GAP=2)
// and one gapless instance (NOTE=4, GAP=0).
module tb_tone_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    tone_sequencer_if ia();
    tone_sequencer_if ib();

    tone_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) u_dut_gap (
        .clk   (clk),
        .reset (reset),
        .sif   (ia.slave)
    );

    tone_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u_dut_nogap (
        .clk   (clk),
        .reset (reset),
        .sif   (ib.slave)
    );

    wire [7:0] obs_a = {ia.select, ia.tone_en, ia.tone_restart, ia.busy, ia.done, ia.start_err};
    wire [7:0] obs_b = {ib.select, ib.tone_en, ib.tone_restart, ib.busy, ib.done, ib.start_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pk(input logic [2:0] s, input logic te, input logic tr,
                                      input logic b, input logic d, input logic e);
        return {s, te, tr, b, d, e};
    endfunction

    // Expected outputs t cycles after an accepted sweep start (gapped build):
    // 4 PLAY cycles then 2 GAP cycles per string, repeating every 6 cycles.
    function automatic logic [7:0] sweep_exp(input int t);
        int pos;
        int k;
        int w;
        pos = t - 1;
        k   = (pos / 6) % 6;
        w   = pos % 6;
        if (w < 4) return pk(3'(k), 1'b1, (w == 0), 1'b1, 1'b0, 1'b0);
        return pk(3'(k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [7:0] nogap_exp(input int t);
        int pos;
        pos = t - 1;
        return pk(3'(pos / 4), 1'b1, ((pos % 4) == 0), 1'b1, 1'b0, 1'b0);
    endfunction

    initial begin
        int restarts;
        checks   = 0;
        failures = 0;
        {ia.start, ia.stop, ia.mode, ia.string_sel, ia.repeat_en} = '0;
        {ib.start, ib.stop, ib.mode, ib.string_sel, ib.repeat_en} = '0;

        // Reset held low with start asserted.
        reset    = 1'b0;
        ia.start = 1'b1;
        step();
        step();
        check("reset_a", obs_a, 8'h00);
        check("reset_b", obs_b, 8'h00);
        reset    = 1'b1;
        ia.start = 1'b0;
        step();
        check("idle_after_reset", obs_a, 8'h00);
        $display("txn reset");

        // Single mode, string 3, held 50 cycles then stopped.
        ia.mode       = 1'b0;
        ia.string_sel = 3'd3;
        ia.start      = 1'b1;
        step();
        ia.start = 1'b0;
        check("single_entry", obs_a, pk(3'd3, 1, 1, 1, 0, 0));
        for (int i = 0; i < 50; i++) begin
            step();
            check("single_hold", obs_a, pk(3'd3, 1, 0, 1, 0, 0));
        end
        ia.stop = 1'b1;
        step();
        ia.stop = 1'b0;
        check("single_stop", {3'b0, obs_a[4:0]}, 8'h00);
        step();
        check("single_stop_idle", {3'b0, obs_a[4:0]}, 8'h00);
        $display("txn single string=3");

        // Rejected single-mode start.
        ia.string_sel = 3'd6;
        ia.start      = 1'b1;
        step();
        ia.start = 1'b0;
        check("invalid_err", {3'b0, obs_a[4:0]}, 8'h01);
        step();
        check("invalid_after", {3'b0, obs_a[4:0]}, 8'h00);
        $display("txn invalid string=6");

        // Sweep without repeat; a start during PLAY must be ignored.
        ia.mode      = 1'b1;
        ia.repeat_en = 1'b0;
        ia.start     = 1'b1;
        step();
        ia.start = 1'b0;
        restarts = 0;
        for (int t = 1; t <= 36; t++) begin
            if (t <= 34)      check("sweep", obs_a, sweep_exp(t));
            else if (t == 35) check("sweep_done", obs_a, pk(3'd5, 0, 0, 1, 1, 0));
            else              check("sweep_idle", {3'b0, obs_a[4:0]}, 8'h00);
            if (ia.tone_restart) restarts++;
            if (t == 2) begin
                ia.start      = 1'b1;
                ia.mode       = 1'b0;
                ia.string_sel = 3'd2;
            end else begin
                ia.start = 1'b0;
                ia.mode  = 1'b1;
            end
            step();
        end
        check("sweep_restart_count", 8'(restarts), 8'd6);
        $display("txn sweep no-repeat");

        // Sweep with repeat; repeat dropped during the second pass.
        ia.repeat_en = 1'b1;
        ia.start     = 1'b1;
        step();
        ia.start = 1'b0;
        for (int t = 1; t <= 72; t++) begin
            if (t <= 70)      check("repeat", obs_a, sweep_exp(t));
            else if (t == 71) check("repeat_done", obs_a, pk(3'd5, 0, 0, 1, 1, 0));
            else              check("repeat_idle", {3'b0, obs_a[4:0]}, 8'h00);
            if (t == 40) ia.repeat_en = 1'b0;
            step();
        end
        $display("txn sweep repeat");

        // start and stop together in IDLE.
        ia.start = 1'b1;
        ia.stop  = 1'b1;
        step();
        ia.start = 1'b0;
        ia.stop  = 1'b0;
        check("start_stop_idle", {3'b0, obs_a[4:0]}, 8'h00);
        step();
        check("start_stop_idle2", {3'b0, obs_a[4:0]}, 8'h00);
        $display("txn start+stop");

        // stop during the first gap.
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        for (int t = 1; t <= 4; t++) step();
        check("gap_state", obs_a, pk(3'd0, 0, 0, 1, 0, 0));
        ia.stop = 1'b1;
        step();
        ia.stop = 1'b0;
        check("gap_stop", {3'b0, obs_a[4:0]}, 8'h00);
        step();
        check("gap_stop_nodone", {3'b0, obs_a[4:0]}, 8'h00);
        $display("txn stop in gap");

        // Gapless build: back-to-back notes.
        ib.mode  = 1'b1;
        ib.start = 1'b1;
        step();
        ib.start = 1'b0;
        for (int t = 1; t <= 26; t++) begin
            if (t <= 24)      check("nogap", obs_b, nogap_exp(t));
            else if (t == 25) check("nogap_done", obs_b, pk(3'd5, 0, 0, 1, 1, 0));
            else              check("nogap_idle", {3'b0, obs_b[4:0]}, 8'h00);
            step();
        end
        $display("txn sweep gapless");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
